// File: rtl/ram_ctrl_pkg.sv
// Shared state encoding and RAM pin bundle for the register-file RAM strobe controller.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SETUP  = 3'd4,
    DONE     = 3'd5
  } ram_ctrl_state_t;

  typedef struct packed {
    logic cs_n;
    logic oe;
    logic ws;
    logic drive;
  } ram_pins_t;

  localparam logic CS_RST    = 1'b1;
  localparam logic OE_RST    = 1'b1;
  localparam logic WS_RST    = 1'b0;
  localparam logic DRIVE_RST = 1'b0;

  localparam ram_pins_t PINS_RST = '{cs_n: CS_RST, oe: OE_RST, ws: WS_RST, drive: DRIVE_RST};

  // Pin levels for the cycle spent in a given state; idle levels everywhere else.
  function automatic ram_pins_t pins_for(input ram_ctrl_state_t st);
    ram_pins_t p;
    p = PINS_RST;
    case (st)
      W_SETUP, W_HOLD: begin
        p.cs_n  = 1'b0;
        p.oe    = 1'b0;
        p.drive = 1'b1;
      end
      W_STROBE: begin
        p.cs_n  = 1'b0;
        p.oe    = 1'b0;
        p.ws    = 1'b1;
        p.drive = 1'b1;
      end
      R_SETUP: begin
        p.cs_n  = 1'b0;
      end
      default: begin
        p = PINS_RST;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ram_controller.sv
// Clocked REQ/ACK front-end that sequences the asynchronous strobe interface of the register-file RAM.
module ram_controller
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 5,
  parameter int SETUP_CYC = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ,
  input  logic             WE,
  input  logic [DEPTH-1:0] A,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             ACK,
  output logic             BUSY,
  output logic [DEPTH-1:0] ADDR,
  output logic             OE,
  output logic             WS,
  output logic             CS,
  inout  wire  [WIDTH-1:0] DATA
);

  localparam int CNT_W = $clog2(SETUP_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ram_ctrl_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  ram_pins_t        pins_q, pins_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          addr_d  = A;
          wdata_d = WDATA;
          cnt_d   = CNT_LOAD;
          state_d = WE ? W_SETUP : R_SETUP;
        end
      end
      W_SETUP: begin
        if (cnt_q == '0) begin
          state_d = W_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      W_STROBE: state_d = W_HOLD;
      W_HOLD:   state_d = DONE;
      R_SETUP: begin
        // The RAM has driven DATA for the whole setup window by the exiting edge.
        if (cnt_q == '0) begin
          rdata_d = DATA;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Every pin is a flop loaded with the level belonging to the state being entered.
    pins_d = pins_for(state_d);
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      pins_q  <= PINS_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      pins_q  <= pins_d;
    end
  end

  assign ADDR  = addr_q;
  assign CS    = pins_q.cs_n;
  assign OE    = pins_q.oe;
  assign WS    = pins_q.ws;
  assign RDATA = rdata_q;
  assign ACK   = ack_q;
  assign BUSY  = busy_q;
  assign DATA  = pins_q.drive ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_controller.sv
// Bench: two controllers (SETUP_CYC=1 and 3), each in front of a behavioural strobe RAM.
module tb_ram_controller;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       req0, we0, req1, we1;
  logic [4:0] a0, a1, addr0, addr1;
  logic [7:0] wd0, wd1, rdata0, rdata1;
  logic       ack0, busy0, oe0, ws0, cs0;
  logic       ack1, busy1, oe1, ws1, cs1;
  wire  [7:0] data0, data1;

  ram_controller #(.WIDTH(8), .DEPTH(5), .SETUP_CYC(S0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req0), .WE(we0), .A(a0), .WDATA(wd0),
    .RDATA(rdata0), .ACK(ack0), .BUSY(busy0), .ADDR(addr0), .OE(oe0),
    .WS(ws0), .CS(cs0), .DATA(data0));

  ram_controller #(.WIDTH(8), .DEPTH(5), .SETUP_CYC(S1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req1), .WE(we1), .A(a1), .WDATA(wd1),
    .RDATA(rdata1), .ACK(ack1), .BUSY(busy1), .ADDR(addr1), .OE(oe1),
    .WS(ws1), .CS(cs1), .DATA(data1));

  // Behavioural RAMs: drive on CS low with OE high, write on the WS rising edge.
  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];
  int ws_cnt0 = 0;
  int ws_cnt1 = 0;
  assign data0 = (!cs0 && oe0) ? mem0[addr0] : 8'bz;
  assign data1 = (!cs1 && oe1) ? mem1[addr1] : 8'bz;
  always @(posedge ws0) begin
    mem0[addr0] <= data0;
    ws_cnt0 <= ws_cnt0 + 1;
  end
  always @(posedge ws1) begin
    mem1[addr1] <= data1;
    ws_cnt1 <= ws_cnt1 + 1;
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [2][32];
  bit         ref_valid [2][32];
  logic [7:0] last_rd [2];

  always @(negedge clk) begin
    checks++;
    if (dut0.pins_q.drive && (oe0 || cs0)) begin
      failures++;
      $display("FAIL contention0 drive=1 oe=%0b cs=%0b required drive only with oe=0 cs=0", oe0, cs0);
    end
    checks++;
    if (dut1.pins_q.drive && (oe1 || cs1)) begin
      failures++;
      $display("FAIL contention1 drive=1 oe=%0b cs=%0b required drive only with oe=0 cs=0", oe1, cs1);
    end
  end

  function automatic int exp_lat(input int sel, input logic w);
    int s;
    s = (sel == 0) ? S0 : S1;
    return w ? s + 3 : s + 1;
  endfunction

  function automatic logic [7:0] get_mem(input int sel, input logic [4:0] ad);
    return (sel == 0) ? mem0[ad] : mem1[ad];
  endfunction

  task automatic drive(input int sel, input logic r, input logic w, input logic [4:0] ad, input logic [7:0] d);
    if (sel == 0) begin
      req0 = r; we0 = w; a0 = ad; wd0 = d;
    end else begin
      req1 = r; we1 = w; a1 = ad; wd1 = d;
    end
  endtask

  // Starts and ends at the sampling point 1 time unit after a rising edge, with the DUT idle.
  task automatic run_txn(input int sel, input logic w, input logic [4:0] ad, input logic [7:0] d,
                         input bit scramble, output int lat, output int wsn, output logic [7:0] rd,
                         output logic busy_acc, output logic after);
    int ws_start;
    drive(sel, 1'b1, w, ad, d);
    @(posedge clk); #1;
    busy_acc = (sel == 0) ? busy0 : busy1;
    ws_start = (sel == 0) ? ws_cnt0 : ws_cnt1;
    if (scramble) drive(sel, 1'b0, 1'($urandom), 5'($urandom), 8'($urandom));
    else          drive(sel, 1'b0, w, ad, d);
    lat = 1;
    while (!((sel == 0) ? ack0 : ack1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = (sel == 0) ? rdata0 : rdata1;
    wsn = ((sel == 0) ? ws_cnt0 : ws_cnt1) - ws_start;
    @(posedge clk); #1;
    after = (sel == 0) ? (ack0 | busy0) : (ack1 | busy1);
    $display("txn sel=%0d we=%0b a=%02h wd=%02h lat=%0d ws=%0d rdata=%02h", sel, w, ad, d, lat, wsn, rd);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cs0, oe0, ws0, ack0, busy0} !== 5'b11000 || addr0 !== 5'd0 || rdata0 !== 8'd0) begin
      failures++;
      $display("FAIL reset0 cs/oe/ws/ack/busy=%b addr=%h rdata=%h required 11000 00 00",
               {cs0, oe0, ws0, ack0, busy0}, addr0, rdata0);
    end
    checks++;
    if ({cs1, oe1, ws1, ack1, busy1} !== 5'b11000 || addr1 !== 5'd0 || rdata1 !== 8'd0) begin
      failures++;
      $display("FAIL reset1 cs/oe/ws/ack/busy=%b addr=%h rdata=%h required 11000 00 00",
               {cs1, oe1, ws1, ack1, busy1}, addr1, rdata1);
    end
    checks++;
    if (dut0.pins_q.drive !== 1'b0 || dut1.pins_q.drive !== 1'b0) begin
      failures++;
      $display("FAIL reset_drive got=%b%b required 00", dut0.pins_q.drive, dut1.pins_q.drive);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat, wsn;
    logic [7:0] rd;
    logic ba, af;
    run_txn(0, 1'b1, 5'h0A, 8'hC3, 1'b0, lat, wsn, rd, ba, af);
    ref_mem[0][5'h0A] = 8'hC3; ref_valid[0][5'h0A] = 1'b1;
    checks++;
    if (lat != 4 || wsn != 1 || ba !== 1'b1 || af !== 1'b0) begin
      failures++;
      $display("FAIL wr_single lat=%0d ws=%0d busy=%0b after=%0b required 4 1 1 0", lat, wsn, ba, af);
    end
    checks++;
    if (mem0[5'h0A] !== 8'hC3) begin
      failures++;
      $display("FAIL wr_single_mem got=%h required c3", mem0[5'h0A]);
    end
    run_txn(0, 1'b0, 5'h0A, 8'h00, 1'b0, lat, wsn, rd, ba, af);
    last_rd[0] = 8'hC3;
    checks++;
    if (lat != 2 || wsn != 0 || rd !== 8'hC3 || af !== 1'b0) begin
      failures++;
      $display("FAIL rd_single lat=%0d ws=%0d rdata=%h after=%0b required 2 0 c3 0", lat, wsn, rd, af);
    end
  endtask

  task automatic test_back_to_back;
    logic       ops_we [4];
    logic [4:0] ops_a  [4];
    logic [7:0] ops_d  [4];
    int edge_n, idx, cur, done, acc_edge, last_ack;
    logic prev_busy;
    ops_we = '{1'b1, 1'b1, 1'b0, 1'b0};
    ops_a  = '{5'd1, 5'd2, 5'd1, 5'd2};
    ops_d  = '{8'h11, 8'h22, 8'h00, 8'h00};
    drive(0, 1'b1, ops_we[0], ops_a[0], ops_d[0]);
    edge_n = 0; idx = 0; cur = 0; done = 0; acc_edge = 0; last_ack = -1;
    prev_busy = busy0;
    while (done < 4 && edge_n < 80) begin
      @(posedge clk); #1;
      edge_n++;
      if (busy0 && !prev_busy) begin
        acc_edge = edge_n;
        cur = idx;
        idx++;
        if (last_ack >= 0) begin
          checks++;
          if (acc_edge - last_ack != 2) begin
            failures++;
            $display("FAIL b2b_gap op=%0d edges=%0d required 2", cur, acc_edge - last_ack);
          end
        end
        if (idx < 4) drive(0, 1'b1, ops_we[idx], ops_a[idx], ops_d[idx]);
        else         drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
      end
      if (ack0) begin
        checks++;
        if (edge_n - acc_edge + 1 != exp_lat(0, ops_we[cur])) begin
          failures++;
          $display("FAIL b2b_lat op=%0d got=%0d required %0d", cur, edge_n - acc_edge + 1, exp_lat(0, ops_we[cur]));
        end
        if (ops_we[cur]) begin
          ref_mem[0][ops_a[cur]] = ops_d[cur];
          ref_valid[0][ops_a[cur]] = 1'b1;
        end else begin
          last_rd[0] = ref_mem[0][ops_a[cur]];
          checks++;
          if (rdata0 !== ref_mem[0][ops_a[cur]]) begin
            failures++;
            $display("FAIL b2b_rdata op=%0d got=%h required %h", cur, rdata0, ref_mem[0][ops_a[cur]]);
          end
        end
        $display("txn b2b op=%0d we=%0b a=%02h rdata=%02h", cur, ops_we[cur], ops_a[cur], rdata0);
        last_ack = edge_n;
        done++;
      end
      prev_busy = busy0;
    end
    checks++;
    if (done != 4) begin
      failures++;
      $display("FAIL b2b_count acks=%0d required 4", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_req_busy;
    int lat, wsn, acks, extra, ws_start;
    logic [7:0] rd, v31, v5;
    logic ba, af, prev_busy;
    v31 = 8'($urandom);
    run_txn(0, 1'b1, 5'h1F, v31, 1'b0, lat, wsn, rd, ba, af);
    ref_mem[0][31] = v31; ref_valid[0][31] = 1'b1;
    v5 = 8'($urandom);
    drive(0, 1'b1, 1'b1, 5'h05, v5);
    @(posedge clk); #1;
    ws_start = ws_cnt0;
    drive(0, 1'b1, 1'b1, 5'h1F, ~v31);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 5'h00, 8'h00);
    acks = 0; extra = 0; prev_busy = busy0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack0) acks++;
      if (busy0 && !prev_busy) extra++;
      prev_busy = busy0;
    end
    ref_mem[0][5] = v5; ref_valid[0][5] = 1'b1;
    $display("txn busy_req a=05 wd=%02h acks=%0d extra_accepts=%0d", v5, acks, extra);
    checks++;
    if (acks != 1 || extra != 0 || ws_cnt0 - ws_start != 1) begin
      failures++;
      $display("FAIL req_busy acks=%0d accepts=%0d ws=%0d required 1 0 1", acks, extra, ws_cnt0 - ws_start);
    end
    checks++;
    if (mem0[31] !== v31 || mem0[5] !== v5) begin
      failures++;
      $display("FAIL req_busy_mem w31=%h w5=%h required %h %h", mem0[31], mem0[5], v31, v5);
    end
  endtask

  task automatic test_reset_midop;
    int lat, wsn, ws_start;
    logic [7:0] rd, old_v, new_v;
    logic ba, af, seen;
    old_v = 8'($urandom);
    new_v = ~old_v;
    run_txn(0, 1'b1, 5'h03, old_v, 1'b0, lat, wsn, rd, ba, af);
    ref_mem[0][3] = old_v; ref_valid[0][3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      // k=0 resets in W_SETUP (write dropped); k=1 in W_STROBE (WS already rose, RAM has the word).
      drive(0, 1'b1, 1'b1, 5'h03, new_v);
      @(posedge clk); #1;
      ws_start = ws_cnt0;
      drive(0, 1'b0, 1'b0, 5'h00, 8'h00);
      if (k == 1) begin
        @(posedge clk); #1;
        checks++;
        if (ws0 !== 1'b1) begin
          failures++;
          $display("FAIL strobe_before_reset ws=%0b required 1", ws0);
        end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({cs0, oe0, ws0, ack0, busy0, dut0.pins_q.drive} !== 6'b110000 || rdata0 !== 8'h00) begin
        failures++;
        $display("FAIL midop_reset%0d cs/oe/ws/ack/busy/drive=%b rdata=%h required 110000 00",
                 k, {cs0, oe0, ws0, ack0, busy0, dut0.pins_q.drive}, rdata0);
      end
      seen = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (ack0) seen = 1'b1;
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (4) begin
        @(posedge clk); #1;
        if (ack0 || busy0) seen = 1'b1;
      end
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
      if (k == 1) ref_mem[0][3] = new_v;
      $display("txn reset_midop case=%0d word=%02h ack_seen=%0b", k, mem0[3], seen);
      checks++;
      if (seen !== 1'b0 || ws_cnt0 - ws_start != k || mem0[3] !== ref_mem[0][3]) begin
        failures++;
        $display("FAIL midop_effect%0d ack_seen=%0b ws=%0d word=%h required 0 %0d %h",
                 k, seen, ws_cnt0 - ws_start, mem0[3], k, ref_mem[0][3]);
      end
    end
    run_txn(0, 1'b0, 5'h03, 8'h00, 1'b0, lat, wsn, rd, ba, af);
    last_rd[0] = ref_mem[0][3];
    checks++;
    if (rd !== ref_mem[0][3] || lat != 2) begin
      failures++;
      $display("FAIL midop_readback rdata=%h lat=%0d required %h 2", rd, lat, ref_mem[0][3]);
    end
  endtask

  task automatic test_setup3;
    int lat, wsn, edge_n, cs_fall, ws_rise, ack_e;
    logic [7:0] rd;
    logic ba, af, prev_cs, prev_ws;
    drive(1, 1'b1, 1'b1, 5'h00, 8'h5A);
    edge_n = 0; cs_fall = -1; ws_rise = -1; ack_e = -1;
    prev_cs = cs1; prev_ws = ws1;
    while (ack_e < 0 && edge_n < 40) begin
      @(posedge clk); #1;
      edge_n++;
      drive(1, 1'b0, 1'b0, 5'h1F, 8'hFF);
      if (!cs1 && prev_cs && cs_fall < 0) cs_fall = edge_n;
      if (ws1 && !prev_ws && ws_rise < 0) ws_rise = edge_n;
      if (ack1) ack_e = edge_n;
      prev_cs = cs1; prev_ws = ws1;
    end
    @(posedge clk); #1;
    ref_mem[1][0] = 8'h5A; ref_valid[1][0] = 1'b1;
    $display("txn setup3 write cs_fall=%0d ws_rise=%0d ack=%0d", cs_fall, ws_rise, ack_e);
    checks++;
    if (cs_fall != 1 || ws_rise - cs_fall != 3 || ack_e != 6) begin
      failures++;
      $display("FAIL setup3_wr cs_fall=%0d ws_gap=%0d ack=%0d required 1 3 6", cs_fall, ws_rise - cs_fall, ack_e);
    end
    run_txn(1, 1'b0, 5'h00, 8'h00, 1'b1, lat, wsn, rd, ba, af);
    last_rd[1] = 8'h5A;
    checks++;
    if (lat != 4 || rd !== 8'h5A || mem1[0] !== 8'h5A) begin
      failures++;
      $display("FAIL setup3_rd lat=%0d rdata=%h word=%h required 4 5a 5a", lat, rd, mem1[0]);
    end
  endtask

  task automatic test_random;
    int sel, lat, wsn;
    logic w, ba, af;
    logic [4:0] ad;
    logic [7:0] d, rd;
    bit scr;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 1);
      w   = 1'($urandom_range(0, 1));
      ad  = 5'($urandom_range(0, 31));
      d   = 8'($urandom);
      scr = 1'($urandom_range(0, 1));
      if (!ref_valid[sel][ad]) w = 1'b1;
      run_txn(sel, w, ad, d, scr, lat, wsn, rd, ba, af);
      checks++;
      if (lat != exp_lat(sel, w) || wsn != int'(w) || ba !== 1'b1 || af !== 1'b0) begin
        failures++;
        $display("FAIL rand_timing i=%0d lat=%0d ws=%0d busy=%0b after=%0b required %0d %0d 1 0",
                 i, lat, wsn, ba, af, exp_lat(sel, w), int'(w));
      end
      if (w) begin
        ref_mem[sel][ad] = d;
        ref_valid[sel][ad] = 1'b1;
        checks++;
        if (get_mem(sel, ad) !== d || rd !== last_rd[sel]) begin
          failures++;
          $display("FAIL rand_write i=%0d word=%h rdata=%h required %h %h", i, get_mem(sel, ad), rd, d, last_rd[sel]);
        end
      end else begin
        last_rd[sel] = ref_mem[sel][ad];
        checks++;
        if (rd !== ref_mem[sel][ad]) begin
          failures++;
          $display("FAIL rand_read i=%0d rdata=%h required %h", i, rd, ref_mem[sel][ad]);
        end
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 32; k++) begin
        ref_valid[s][k] = 1'b0;
        ref_mem[s][k] = 8'h00;
      end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_req_busy();
    test_reset_midop();
    test_setup3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
